// File: rtl/controle_pkg.sv
// Shared types and defaults for the counter sequencer.
// Optional up/down counting is enabled with CONTROLE_UPDOWN_EN.
package controle_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int PRESC_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/controle_contador_if.sv
// Control and display bundle between stimulus and the sequencer.
// CONTROLE_UPDOWN_EN adds the dir control line.
interface controle_contador_if #(
    parameter int WIDTH = 4
) ();

    logic             start;
    logic             pause;
    logic             clear;
    logic             wrap;
    logic [WIDTH-1:0] limit;
`ifdef CONTROLE_UPDOWN_EN
    logic             dir;
`endif
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             done;
    logic             busy;
    logic [1:0]       state;

    modport master (
        output start, pause, clear, wrap, limit,
`ifdef CONTROLE_UPDOWN_EN
        output dir,
`endif
        input  count, tick, done, busy, state
    );

    modport slave (
        input  start, pause, clear, wrap, limit,
`ifdef CONTROLE_UPDOWN_EN
        input  dir,
`endif
        output count, tick, done, busy, state
    );

endinterface

// File: rtl/divisor_tick.sv
// Prescaler: one tick every PRESC enabled cycles.
// Phase is held while disabled and zeroed by clr.
module divisor_tick #(
    parameter int PRESC = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clr,
    output logic tick
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESC - 1);

    logic [PW-1:0] presc;

    assign tick = enable && (presc == LAST);

    // Phase counter: wraps on tick, freezes when not enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (clr) begin
            presc <= '0;
        end else if (enable) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

endmodule

// File: rtl/controle_contador.sv
// Counter sequencer: start/pause/clear FSM, prescaled ticks, wrap or stop.
// CONTROLE_UPDOWN_EN enables down counting selected by dir at start.
module controle_contador
    import controle_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int PRESC = PRESC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    controle_contador_if.slave bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q;
    logic             wrap_q;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             wrap_hit;
    logic             start_go;
    logic             enable;
    logic             ptick;
    logic             down;
    logic [WIDTH-1:0] new_start;
    logic [WIDTH-1:0] run_start;
    logic [WIDTH-1:0] term;

`ifdef CONTROLE_UPDOWN_EN
    logic dir_q;

    assign down      = dir_q;
    assign new_start = bus.dir ? bus.limit : '0;

    // Direction is latched only when a run is launched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q <= 1'b0;
        end else if (start_go) begin
            dir_q <= bus.dir;
        end
    end
`else
    assign down      = 1'b0;
    assign new_start = '0;
`endif

    assign run_start = down ? limit_q : '0;
    assign term      = down ? '0 : limit_q;

    // clear beats pause, pause beats start.
    assign start_go = bus.start && !bus.clear && !bus.pause
                   && (state_q == IDLE || state_q == DONE);
    assign enable   = (state_q == RUN) && !bus.pause && !bus.clear;

    divisor_tick #(
        .PRESC (PRESC)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clr    (bus.clear || start_go),
        .tick   (ptick)
    );

    // Next-state, next-count and pulse decode.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        tick_d   = 1'b0;
        wrap_hit = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
            count_d = '0;
        end else if (start_go) begin
            state_d = RUN;
            count_d = new_start;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.pause) begin
                        state_d = PAUSE;
                    end else if (ptick) begin
                        tick_d = 1'b1;
                        if (count_q != term) begin
                            count_d = down ? count_q - 1'b1
                                           : count_q + 1'b1;
                        end else if (wrap_q) begin
                            count_d  = run_start;
                            wrap_hit = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                PAUSE: begin
                    if (!bus.pause) begin
                        state_d = RUN;
                    end
                end
                default: begin
                end
            endcase
        end
        done_d = (state_d == DONE) || wrap_hit;
    end

    // State, count and registered pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    // Run configuration, captured only on launch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            limit_q <= '0;
            wrap_q  <= 1'b0;
        end else if (start_go) begin
            limit_q <= bus.limit;
            wrap_q  <= bus.wrap;
        end
    end

    assign bus.count = count_q;
    assign bus.tick  = tick_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state_q == RUN) || (state_q == PAUSE);
    assign bus.state = state_q;

endmodule
